// File: rtl/cpu_memory_responder.sv
// Loadable 16x8 program RAM for the CPU bus: zero-fills on boot, streams an image in, then serves reads and writes.
// Read path is combinational from address (0 cycles); writes land on the next rising edge.
// boot_ready is high only in LOAD; cpu_hold keeps the CPU off until the image is in; strobes while held are dropped and flagged.
module cpu_memory_responder #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] memoryIn,
  output logic [DATA_W-1:0] memoryOut,
  input  logic              boot_valid,
  input  logic [DATA_W-1:0] boot_data,
  input  logic              boot_last,
  output logic              boot_ready,
  input  logic              reload,
  output logic              cpu_hold,
  output logic              bad_access
);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_bad;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_din;

  // Pick the single array write port source: clear pointer, boot stream, or CPU.
  always_comb begin
    w_mem_we   = 1'b0;
    w_mem_addr = r_ptr;
    w_mem_din  = '0;
    case (r_state)
      ST_CLEAR: begin
        w_mem_we = 1'b1;
      end
      ST_LOAD: begin
        w_mem_we  = boot_valid;
        w_mem_din = boot_data;
      end
      ST_RUN: begin
        w_mem_we   = write;
        w_mem_addr = address;
        w_mem_din  = memoryIn;
      end
      default: begin
        w_mem_we = 1'b0;
      end
    endcase
  end

  // Array storage: no reset, CLEAR overwrites every location after reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_din;
    end
  end

  // Boot sequencer: clear sweep, image load, then run until reload.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= ST_CLEAR;
      r_ptr   <= '0;
      r_bad   <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          if (read || write) r_bad <= 1'b1;
          if (r_ptr == LP_LAST) begin
            r_state <= ST_LOAD;
            r_ptr   <= '0;
          end else begin
            r_ptr <= r_ptr + 1'b1;
          end
        end
        ST_LOAD: begin
          if (read || write) r_bad <= 1'b1;
          if (boot_valid) begin
            // A full image ends on the last location even without boot_last.
            if (boot_last || (r_ptr == LP_LAST)) begin
              r_state <= ST_RUN;
              r_ptr   <= '0;
            end else begin
              r_ptr <= r_ptr + 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (reload) begin
            r_state <= ST_CLEAR;
            r_ptr   <= '0;
            r_bad   <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_CLEAR;
          r_ptr   <= '0;
        end
      endcase
    end
  end

  // Status outputs decode straight from the state register.
  always_comb begin
    boot_ready = (r_state == ST_LOAD);
    cpu_hold   = (r_state != ST_RUN);
    bad_access = r_bad;
    memoryOut  = (r_state == ST_RUN) ? r_mem[address] : '0;
  end

endmodule

// File: tb/tb_cpu_memory_responder.sv
// Directed bench for cpu_memory_responder with an image-level reference model.
// Inputs change 1 time unit after the rising edge; the model is checked on every falling edge.
// Literal expectations at key points pin the model to hand-computed values.
module tb_cpu_memory_responder;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       read = 1'b0;
  logic       write = 1'b0;
  logic [3:0] address = '0;
  logic [7:0] memoryIn = '0;
  logic [7:0] memoryOut;
  logic       boot_valid = 1'b0;
  logic [7:0] boot_data = '0;
  logic       boot_last = 1'b0;
  logic       boot_ready;
  logic       reload = 1'b0;
  logic       cpu_hold;
  logic       bad_access;

  int n_chk = 0;
  int n_err = 0;

  cpu_memory_responder #(.ADDR_W(4), .DATA_W(8), .DEPTH(16)) dut (
    .clk(clk), .clr(clr), .read(read), .write(write), .address(address),
    .memoryIn(memoryIn), .memoryOut(memoryOut), .boot_valid(boot_valid),
    .boot_data(boot_data), .boot_last(boot_last), .boot_ready(boot_ready),
    .reload(reload), .cpu_hold(cpu_hold), .bad_access(bad_access)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 = clearing, 1 = loading, 2 = running.
  int         m_phase = 0;
  int         m_cleared = 0;
  int         m_loaded = 0;
  logic       m_bad = 1'b0;
  logic [7:0] m_mem [16];

  initial for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      m_phase = 0; m_cleared = 0; m_bad = 1'b0;
    end else if (m_phase == 0) begin
      if (read || write) m_bad = 1'b1;
      m_mem[m_cleared] = 8'h00;
      m_cleared = m_cleared + 1;
      if (m_cleared == 16) begin m_phase = 1; m_loaded = 0; end
    end else if (m_phase == 1) begin
      if (read || write) m_bad = 1'b1;
      if (boot_valid) begin
        m_mem[m_loaded] = boot_data;
        m_loaded = m_loaded + 1;
        if (boot_last || m_loaded == 16) m_phase = 2;
      end
    end else begin
      if (write) m_mem[address] = memoryIn;
      if (reload) begin m_phase = 0; m_cleared = 0; m_bad = 1'b0; end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    check("model memoryOut", memoryOut, (m_phase == 2) ? m_mem[address] : 8'h00);
    check("model boot_ready", boot_ready, m_phase == 1);
    check("model cpu_hold", cpu_hold, m_phase != 2);
    check("model bad_access", bad_access, m_bad);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] exp, input string name);
    tick();
    address = a;
    #1;
    check(name, memoryOut, exp);
  endtask

  task automatic wait_clear();
    repeat (15) tick();
    check("ready low through clear", boot_ready, 1'b0);
    check("hold high through clear", cpu_hold, 1'b1);
    tick();
    check("ready after 16 clears", boot_ready, 1'b1);
  endtask

  task automatic boot_byte(input logic [7:0] d, input logic last);
    boot_valid = 1'b1; boot_data = d; boot_last = last;
    tick();
    boot_valid = 1'b0; boot_last = 1'b0;
  endtask

  task automatic do_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
    check("hold after reload", cpu_hold, 1'b1);
    check("ready low after reload", boot_ready, 1'b0);
  endtask

  logic [7:0] short_img [16];

  initial begin
    // Reset and clear
    repeat (2) tick();
    check("reset hold", cpu_hold, 1'b1);
    check("reset ready", boot_ready, 1'b0);
    check("reset bad", bad_access, 1'b0);
    check("reset memoryOut", memoryOut, 8'h00);
    clr = 1'b1;
    wait_clear();

    // Short boot
    boot_byte(8'h11, 1'b0);
    boot_byte(8'h22, 1'b0);
    check("hold during load", cpu_hold, 1'b1);
    boot_byte(8'h33, 1'b1);
    check("run after last", cpu_hold, 1'b0);
    check("ready low in run", boot_ready, 1'b0);
    for (int i = 0; i < 16; i++) short_img[i] = 8'h00;
    short_img[0] = 8'h11; short_img[1] = 8'h22; short_img[2] = 8'h33;
    for (int i = 0; i < 16; i++) rd(4'(i), short_img[i], "short image");

    // CPU write/read, read-before-write
    tick();
    address = 4'd7; memoryIn = 8'h5C; write = 1'b1;
    #1 check("old data before write", memoryOut, 8'h00);
    tick();
    write = 1'b0;
    check("write visible", memoryOut, 8'h5C);
    read = 1'b1; write = 1'b1; memoryIn = 8'hA5;
    #1 check("rw old data", memoryOut, 8'h5C);
    tick();
    read = 1'b0; write = 1'b0;
    check("rw write done", memoryOut, 8'hA5);

    // Reload: clear all, boot a single zero byte, everything reads zero
    do_reload();
    wait_clear();
    boot_byte(8'h00, 1'b1);
    for (int i = 0; i < 16; i++) rd(4'(i), 8'h00, "cleared after reload");

    // Full boot without boot_last, then an extra byte that must be ignored
    do_reload();
    wait_clear();
    for (int i = 0; i < 16; i++) begin
      check("hold before full image", cpu_hold, 1'b1);
      boot_byte(8'hA0 + 8'(i), 1'b0);
    end
    check("run after 16 bytes", cpu_hold, 1'b0);
    boot_byte(8'h77, 1'b0);
    rd(4'd15, 8'hAF, "full image last");
    rd(4'd0, 8'hA0, "17th byte ignored");
    rd(4'd5, 8'hA5, "full image mid");

    // Hold violation during LOAD
    do_reload();
    wait_clear();
    address = 4'd2; memoryIn = 8'hFF; write = 1'b1;
    tick();
    write = 1'b0;
    check("bad after held write", bad_access, 1'b1);
    boot_byte(8'h01, 1'b0);
    boot_byte(8'h02, 1'b1);
    rd(4'd2, 8'h00, "held write discarded");
    rd(4'd0, 8'h01, "boot after violation");
    check("bad sticky in run", bad_access, 1'b1);

    // Reload clears the flag; reload in LOAD ignored; reset mid-load restarts
    do_reload();
    check("bad cleared by reload", bad_access, 1'b0);
    wait_clear();
    reload = 1'b1;
    tick();
    reload = 1'b0;
    check("reload ignored in load", boot_ready, 1'b1);
    boot_byte(8'h55, 1'b0);
    boot_byte(8'h66, 1'b0);
    clr = 1'b0;
    #1;
    check("async reset hold", cpu_hold, 1'b1);
    check("async reset ready", boot_ready, 1'b0);
    tick();
    clr = 1'b1;
    wait_clear();
    boot_byte(8'h99, 1'b1);
    rd(4'd0, 8'h99, "reboot byte");
    rd(4'd1, 8'h00, "partial image overwritten");
    rd(4'd15, 8'h00, "tail cleared");

    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
